// File: rtl/gp_regfile_dbg_pkg.sv
// Shared definitions for the i281 general-purpose register file slice.
// Holds the dump engine state encoding, the default datapath geometry
// reused by the register file top, and a small index range helper.
package regfile_pkg;

  // Dump engine states; encodings are fixed so the board display and UART
  // bridge can decode a probed state value directly.
  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SHOW = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_t;

  // Default geometry of the original ABCD file.
  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_NUM_REGS = 4;
  localparam int unsigned DEF_ADDR_W   = 2;

  // True when a (zero-extended) register index names an existing register.
  // NUM_REGS need not be a power of two, so the top index codes can be empty.
  function automatic logic idx_in_range(input int unsigned idx,
                                        input int unsigned num_regs);
    return idx < num_regs;
  endfunction

endpackage

// File: rtl/gp_regfile_dbg_if.sv
// Debug dump stream of the register file.
// Signals:
//   dump_start  consumer -> file   start a dump (pulse or level)
//   dump_ready  consumer -> file   current beat accepted
//   dump_valid  file -> consumer   a beat is presented
//   dump_idx    file -> consumer   register index of the beat
//   dump_data   file -> consumer   snapshot of that register
//   dump_busy   file -> consumer   engine not idle
//   dump_done   file -> consumer   one-cycle pulse after the last accept
// Modports: master = consumer (display/UART side), slave = register file.
interface gp_regfile_dbg_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              dump_start;
  logic              dump_ready;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_busy;
  logic              dump_done;

  modport master (
    output dump_start,
    output dump_ready,
    input  dump_valid,
    input  dump_idx,
    input  dump_data,
    input  dump_busy,
    input  dump_done
  );

  modport slave (
    input  dump_start,
    input  dump_ready,
    output dump_valid,
    output dump_idx,
    output dump_data,
    output dump_busy,
    output dump_done
  );

endinterface

// File: rtl/gp_regfile_dbg_dump_fsm.sv
// Dump engine: walks register indices 0..NUM_REGS-1 with a valid/ready
// handshake, capturing a snapshot of each register as its beat is loaded.
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   dump_start/ready    handshake inputs from the consumer
//   dump_valid/idx/data presented beat
//   dump_busy/done      engine status
//   snap_idx            register index the engine wants to load this cycle
//   snap_data           stored contents of register snap_idx (from the file)
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done,
  output logic [ADDR_W-1:0] snap_idx,
  input  logic [DATA_W-1:0] snap_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_t       state_q, state_d;
  logic              load;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      // Snapshot is the stored value ahead of any write on this same edge.
      if (load) begin
        idx_q  <= snap_idx;
        data_q <= snap_data;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    snap_idx = '0;
    case (state_q)
      DUMP_IDLE: begin
        if (dump_start) begin
          state_d  = DUMP_SHOW;
          load     = 1'b1;
          snap_idx = '0;
        end
      end
      DUMP_SHOW: begin
        if (dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DUMP_DONE;
          end else begin
            load     = 1'b1;
            snap_idx = idx_q + 1'b1;
          end
        end
      end
      DUMP_DONE: begin
        state_d = DUMP_IDLE;
      end
      default: begin
        state_d = DUMP_IDLE;
      end
    endcase
  end

  always_comb begin
    dump_valid = (state_q == DUMP_SHOW);
    dump_busy  = (state_q != DUMP_IDLE);
    dump_done  = (state_q == DUMP_DONE);
    dump_idx   = idx_q;
    dump_data  = data_q;
  end

endmodule

// File: rtl/gp_regfile_dbg.sv
// Parametrised general-purpose register file for the multicycle i281
// datapath: one write port, two combinational read ports with optional
// write-to-read bypass, a run-qualified clear-all, and a debug dump engine.
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   run                   CPU run enable, qualifies wr_en and clr
//   wr_en/wr_addr/wr_data write port (out-of-range index is ignored)
//   clr                   clear all registers (wins over a write)
//   rd_addr_a/rd_data_a   read port A (out-of-range index reads 0)
//   rd_addr_b/rd_data_b   read port B
//   dump                  debug dump stream (slave side)
module gp_regfile_dbg
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  gp_regfile_dbg_if.slave   dump
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              clr_hit;
  logic              wr_hit;
  logic [ADDR_W-1:0] snap_idx;
  logic [DATA_W-1:0] snap_data;

  assign clr_hit = run & clr;
  assign wr_hit  = run & wr_en & ~clr & idx_in_range(32'(wr_addr), NUM_REGS);

  // Storage. Writes decode per register so an index with no backing
  // register simply matches nothing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (clr_hit) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_addr == ADDR_W'(i)) regs[i] <= wr_data;
      end
    end
  end

  // Read port A
  always_comb begin
    rd_data_a = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_a == ADDR_W'(i)) rd_data_a = regs[i];
    end
    if (BYPASS) begin
      if (clr_hit) begin
        rd_data_a = '0;
      end else if (wr_hit && (wr_addr == rd_addr_a)) begin
        rd_data_a = wr_data;
      end
    end
  end

  // Read port B
  always_comb begin
    rd_data_b = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_b == ADDR_W'(i)) rd_data_b = regs[i];
    end
    if (BYPASS) begin
      if (clr_hit) begin
        rd_data_b = '0;
      end else if (wr_hit && (wr_addr == rd_addr_b)) begin
        rd_data_b = wr_data;
      end
    end
  end

  // Snapshot source for the dump engine: stored contents only, never bypassed.
  always_comb begin
    snap_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (snap_idx == ADDR_W'(i)) snap_data = regs[i];
    end
  end

  regfile_dump_fsm #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_dump (
    .clock      (clock),
    .reset      (reset),
    .dump_start (dump.dump_start),
    .dump_ready (dump.dump_ready),
    .dump_valid (dump.dump_valid),
    .dump_idx   (dump.dump_idx),
    .dump_data  (dump.dump_data),
    .dump_busy  (dump.dump_busy),
    .dump_done  (dump.dump_done),
    .snap_idx   (snap_idx),
    .snap_data  (snap_data)
  );

endmodule

// File: tb/tb_gp_regfile_dbg.sv
// Self-checking bench for gp_regfile_dbg: a bypassing and a non-bypassing
// 4x8 file driven in lockstep, plus a 5-register file with 3-bit indices.
module tb_gp_regfile_dbg;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] data;
  } beat_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       run, wr_en, clr;
  logic [1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [7:0] wr_data;
  logic [7:0] rda_b1, rdb_b1, rda_b0, rdb_b0;
  logic [2:0] wr_addr5, rd_addr_a5, rd_addr_b5;
  logic [7:0] rda_5, rdb_5;

  int    checks   = 0;
  int    errors   = 0;
  int    done_cnt = 0;
  beat_t exp_q[$];

  gp_regfile_dbg_if #(.DATA_W(8), .ADDR_W(2)) d4b ();
  gp_regfile_dbg_if #(.DATA_W(8), .ADDR_W(2)) d4n ();
  gp_regfile_dbg_if #(.DATA_W(8), .ADDR_W(3)) d5 ();

  gp_regfile_dbg #(.DATA_W(8), .NUM_REGS(4), .ADDR_W(2), .BYPASS(1'b1)) u4b (
    .clock(clock), .reset(reset), .run(run), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr(clr), .rd_addr_a(rd_addr_a), .rd_data_a(rda_b1),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb_b1), .dump(d4b));

  gp_regfile_dbg #(.DATA_W(8), .NUM_REGS(4), .ADDR_W(2), .BYPASS(1'b0)) u4n (
    .clock(clock), .reset(reset), .run(run), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr(clr), .rd_addr_a(rd_addr_a), .rd_data_a(rda_b0),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb_b0), .dump(d4n));

  gp_regfile_dbg #(.DATA_W(8), .NUM_REGS(5), .ADDR_W(3), .BYPASS(1'b1)) u5 (
    .clock(clock), .reset(reset), .run(run), .wr_en(wr_en), .wr_addr(wr_addr5),
    .wr_data(wr_data), .clr(clr), .rd_addr_a(rd_addr_a5), .rd_data_a(rda_5),
    .rd_addr_b(rd_addr_b5), .rd_data_b(rdb_5), .dump(d5));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Beat scoreboard: a beat counts when valid & ready are seen mid-cycle,
  // i.e. it will be accepted on the coming rising edge.
  always @(negedge clock) begin
    if (!reset && d4b.dump_valid && d4b.dump_ready) begin
      check("beat_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        beat_t b;
        b = exp_q.pop_front();
        check("beat_idx", 32'(d4b.dump_idx), 32'(b.idx));
        check("beat_data", 32'(d4b.dump_data), 32'(b.data));
      end
    end
    if (!reset && d4b.dump_done) done_cnt++;
  end

  initial begin
    reset = 1'b1; run = 1'b0; wr_en = 1'b0; clr = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    wr_addr5 = '0; rd_addr_a5 = '0; rd_addr_b5 = '0;
    d4b.dump_start = 1'b0; d4b.dump_ready = 1'b0;
    d4n.dump_start = 1'b0; d4n.dump_ready = 1'b1;
    d5.dump_start  = 1'b0; d5.dump_ready  = 1'b1;
    #1;
    check("rst_rd_a", 32'(rda_b1), 32'h00);
    check("rst_valid", 32'(d4b.dump_valid), 32'd0);
    check("rst_busy", 32'(d4b.dump_busy), 32'd0);
    check("rst_done", 32'(d4b.dump_done), 32'd0);
    check("rst_idx", 32'(d4b.dump_idx), 32'd0);
    check("rst_data", 32'(d4b.dump_data), 32'd0);
    tick(); tick();
    reset = 1'b0;

    // Basic writes and reads
    run = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hA5;
    tick();
    wr_addr = 2'd3; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0; rd_addr_a = 2'd1; rd_addr_b = 2'd3;
    #1;
    check("rd_a_reg1", 32'(rda_b1), 32'hA5);
    check("rd_b_reg3", 32'(rdb_b1), 32'h3C);
    rd_addr_a = 2'd0; rd_addr_b = 2'd2;
    #1;
    check("rd_a_reg0", 32'(rda_b1), 32'h00);
    check("rd_b_reg2", 32'(rdb_b1), 32'h00);

    // Same-cycle write with and without bypass
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h7E; rd_addr_a = 2'd2;
    #1;
    check("byp1_before", 32'(rda_b1), 32'h7E);
    check("byp0_before", 32'(rda_b0), 32'h00);
    tick();
    wr_en = 1'b0;
    #1;
    check("byp1_after", 32'(rda_b1), 32'h7E);
    check("byp0_after", 32'(rda_b0), 32'h7E);

    // run = 0 blocks the write and the bypass
    run = 1'b0; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF; rd_addr_a = 2'd0;
    #1;
    check("norun_bypass", 32'(rda_b1), 32'h00);
    tick();
    wr_en = 1'b0; run = 1'b1;
    #1;
    check("norun_hold", 32'(rda_b1), 32'h00);

    // Clear beats a simultaneous write
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h55; clr = 1'b1;
    rd_addr_a = 2'd1; rd_addr_b = 2'd3;
    #1;
    check("clr_byp_a", 32'(rda_b1), 32'h00);
    check("clr_byp_b", 32'(rdb_b1), 32'h00);
    check("clr_nobyp_a", 32'(rda_b0), 32'hA5);
    check("clr_nobyp_b", 32'(rdb_b0), 32'h3C);
    tick();
    clr = 1'b0; wr_en = 1'b0;
    #1;
    check("clr_reg1", 32'(rda_b1), 32'h00);
    check("clr_reg3", 32'(rdb_b1), 32'h00);
    rd_addr_a = 2'd2;
    #1;
    check("clr_reg2", 32'(rda_b0), 32'h00);

    // Load 11/22/33/44 and dump with ready tied high
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 2'(i); wr_data = 8'((i + 1) * 8'h11);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back('{idx: 2'(i), data: 8'((i + 1) * 8'h11)});
    d4b.dump_ready = 1'b1; d4b.dump_start = 1'b1;
    tick();
    d4b.dump_start = 1'b0;
    check("d1_first_valid", 32'(d4b.dump_valid), 32'd1);
    check("d1_first_busy", 32'(d4b.dump_busy), 32'd1);
    check("d1_first_idx", 32'(d4b.dump_idx), 32'd0);
    tick(); tick(); tick();
    check("d1_last_idx", 32'(d4b.dump_idx), 32'd3);
    tick();
    check("d1_done", 32'(d4b.dump_done), 32'd1);
    check("d1_done_valid", 32'(d4b.dump_valid), 32'd0);
    check("d1_done_busy", 32'(d4b.dump_busy), 32'd1);
    tick();
    check("d1_idle_done", 32'(d4b.dump_done), 32'd0);
    check("d1_idle_busy", 32'(d4b.dump_busy), 32'd0);
    check("d1_done_count", 32'(done_cnt), 32'd1);
    check("d1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Back-pressure with a write to the held register
    for (int i = 0; i < 4; i++) exp_q.push_back('{idx: 2'(i), data: 8'((i + 1) * 8'h11)});
    d4b.dump_ready = 1'b1; d4b.dump_start = 1'b1;
    tick();
    d4b.dump_start = 1'b0;
    tick();
    d4b.dump_ready = 1'b0; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h99;
    tick();
    wr_en = 1'b0; rd_addr_a = 2'd1;
    #1;
    check("bp_hold_idx", 32'(d4b.dump_idx), 32'd1);
    check("bp_hold_data", 32'(d4b.dump_data), 32'h22);
    check("bp_reg1_new", 32'(rda_b1), 32'h99);
    tick();
    check("bp_hold2_data", 32'(d4b.dump_data), 32'h22);
    d4b.dump_ready = 1'b1;
    tick();
    check("bp_next_idx", 32'(d4b.dump_idx), 32'd2);
    tick(); tick();
    check("bp_done", 32'(d4b.dump_done), 32'd1);
    tick();
    check("bp_done_count", 32'(done_cnt), 32'd2);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while index 2 is presented
    exp_q.push_back('{idx: 2'd0, data: 8'h11});
    exp_q.push_back('{idx: 2'd1, data: 8'h99});
    d4b.dump_ready = 1'b1; d4b.dump_start = 1'b1;
    tick();
    d4b.dump_start = 1'b0;
    tick(); tick();
    d4b.dump_ready = 1'b0;
    #1;
    check("rstmid_idx", 32'(d4b.dump_idx), 32'd2);
    reset = 1'b1;
    #1;
    check("rstmid_valid", 32'(d4b.dump_valid), 32'd0);
    check("rstmid_busy", 32'(d4b.dump_busy), 32'd0);
    check("rstmid_didx", 32'(d4b.dump_idx), 32'd0);
    check("rstmid_data", 32'(d4b.dump_data), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rstmid_no_done", 32'(done_cnt), 32'd2);
    check("rstmid_queue", 32'(exp_q.size()), 32'd0);
    check("rstmid_reg1", 32'(rda_b1), 32'h00);
    check("idle_d4n_busy", 32'(d4n.dump_busy), 32'd0);
    check("idle_d5_busy", 32'(d5.dump_busy), 32'd0);

    // Five-register file: index 6 has no register
    wr_en = 1'b1; wr_addr5 = 3'd6; wr_data = 8'hAB; rd_addr_a5 = 3'd6;
    #1;
    check("n5_oor_bypass", 32'(rda_5), 32'h00);
    tick();
    wr_addr5 = 3'd4; wr_data = 8'hCD;
    tick();
    wr_en = 1'b0; rd_addr_b5 = 3'd4;
    #1;
    check("n5_oor_read", 32'(rda_5), 32'h00);
    check("n5_reg4", 32'(rdb_5), 32'hCD);
    for (int i = 0; i < 4; i++) begin
      rd_addr_a5 = 3'(i);
      #1;
      check("n5_untouched", 32'(rda_5), 32'h00);
    end
    rd_addr_a5 = 3'd5;
    #1;
    check("n5_oor5_read", 32'(rda_5), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gp_regfile_dbg.md
Name: gp_regfile_dbg

Overview:
Parametrised general-purpose register file for the multicycle i281 datapath. It replaces the fixed 4x8 ABCD file and has these features:
- one write port and two combinational read ports;
- an optional write-to-read bypass;
- a synchronous clear-all;
- a handshaked debug dump engine that streams every register out in index order for the board display or UART, working while the CPU runs or is halted.

Parameters:
DATA_W, 8, register width in bits
NUM_REGS, 4, number of registers (2..16; need not be a power of 2)
ADDR_W, 2, index width; must satisfy 2**ADDR_W >= NUM_REGS
BYPASS, 1, 1 = read ports forward the same-cycle write data; 0 = read ports show stored contents only

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all registers and the dump engine
run  in  1  CPU run enable; gates wr_en and clr
wr_en  in  1  write strobe (control word c10 equivalent)
wr_addr  in  ADDR_W  write register index
wr_data  in  DATA_W  write data
clr  in  1  clear all registers (qualified by run)
rd_addr_a  in  ADDR_W  read port A index
rd_data_a  out  DATA_W  read port A data
rd_addr_b  in  ADDR_W  read port B index
rd_data_b  out  DATA_W  read port B data
dump_start  in  1  start a dump; single-cycle pulse or level
dump_ready  in  1  consumer accepts the current dump beat
dump_valid  out  1  a dump beat is presented
dump_idx  out  ADDR_W  index of the presented register
dump_data  out  DATA_W  snapshot of the presented register
dump_busy  out  1  dump engine not IDLE
dump_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (async, immediate): all registers = 0, FSM = IDLE, dump_valid/dump_busy/dump_done = 0, dump_idx = 0, dump_data = 0. Reset mid-dump aborts the dump with no dump_done.
- Write:
  - At a rising edge with run & wr_en & !clr, reg[wr_addr] <= wr_data.
  - wr_addr >= NUM_REGS is ignored; no register changes.
- Clear: at a rising edge with run & clr, all registers <= 0. clr beats wr_en in the same cycle.
- run = 0: registers hold regardless of wr_en and clr.
- Reads:
  - Purely combinational and sensitive to the addresses and all register contents, so no stale outputs.
  - rd_addr >= NUM_REGS reads 0.
  - BYPASS=1: if run & wr_en & !clr and wr_addr == rd_addr (in range), the port shows wr_data.
  - BYPASS=1: if run & clr, both ports show 0.
  - BYPASS=0: ports always show stored contents.
- Dump FSM states: IDLE, SHOW, DONE.
  - IDLE: dump_start=1 -> SHOW. dump_idx <= 0, dump_data <= reg[0] (stored value before this edge's write).
  - SHOW: dump_valid=1, dump_busy=1. dump_idx and dump_data hold while dump_ready=0.
  - SHOW, on valid & ready: if dump_idx == NUM_REGS-1 -> DONE. Otherwise dump_idx++ and dump_data <= reg[dump_idx+1] (stored value before the edge).
  - DONE: dump_done=1, dump_busy=1, dump_valid=0 for exactly one cycle -> IDLE.
- The snapshot is taken at load. Later writes to the displayed register do not change dump_data.
- dump_start is ignored while busy. A level-high start re-triggers from IDLE, giving back-to-back dumps separated by the DONE cycle.
- The dump engine ignores run and never modifies registers.
- Single-beat latency: start -> first valid = 1 cycle; last accept -> done = 1 cycle; minimum dump with ready tied high = NUM_REGS + 2 cycles including the IDLE exit.

Decomposition:
- Shared package regfile_pkg holds:
  - dump state encoding (IDLE=2'd0, SHOW=2'd1, DONE=2'd2);
  - default DATA_W/NUM_REGS constants reused by the datapath top.
- One natural sub-module, regfile_dump_fsm: the FSM, index counter and handshake. It takes the register read value via an index/data pair. Storage, write/clear logic and read muxes stay in gp_regfile_dbg.

Test Plan:
- Reset, then write A5 to reg1, 3C to reg3 (run=1) -> rd_addr_a=1 gives A5, rd_addr_b=3 gives 3C, reg0 and reg2 read 00.
- BYPASS=1, same-cycle write 7E to reg2 with rd_addr_a=2 -> rd_data_a=7E before the edge and after it. Repeat with BYPASS=0 -> old value before the edge, 7E after.
- run=0 with wr_en=1 and data FF to reg0 -> reg0 unchanged. clr=1 with wr_en=1 to reg1 (run=1) -> all regs 00 and no write.
- Regs 11/22/33/44, ready tied 1, one start pulse -> beats idx0..3 with data 11,22,33,44 on consecutive cycles, then a single dump_done cycle.
- Dump with ready toggled 1,0,0,1; write 99 to reg1 while idx1 is held -> data stays 22 until accepted, no beat lost or duplicated.
- Reset asserted during idx2 of a dump -> immediately valid=0, busy=0, no done; NUM_REGS=5 instance write to addr 6 ignored and reads 00.
